// File: rtl/vector_pack_engine.sv
// vector_pack_engine: packs one computed lane per accepted beat into a LANES*W frame, lane 0 in the MSBs.
// Optional feature macro VECPACK_PARITY_EN adds out_parity (per-lane even parity, lane 0 in the MSB).
module vector_pack_engine #(
  parameter  int W     = 8,
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [1:0]         in_mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [CW-1:0]      out_count
`ifdef VECPACK_PARITY_EN
  ,
  output logic [LANES-1:0]   out_parity
`endif
);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           wr_idx_q, wr_idx_d;
  logic [LANES-1:0][W-1:0] lanes_q, lanes_d;
  logic [LANES*W-1:0]      out_data_q, out_data_d;
  logic [CW-1:0]           out_count_q, out_count_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    beat_s, close_s;

  function automatic logic [W-1:0] lane_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] mode);
    case (mode)
      2'b00:   lane_op = a;
      2'b01:   lane_op = b;
      2'b10:   lane_op = a + b;
      2'b11:   lane_op = a - b;
      default: lane_op = a;
    endcase
  endfunction

  function automatic logic [LANES*W-1:0] pack(input logic [LANES-1:0][W-1:0] lanes);
    pack = '0;
    for (int i = 0; i < LANES; i++) pack[(LANES-1-i)*W +: W] = lanes[i];
  endfunction

  // Next-state: lane writes, frame close on full or flush, release on out_ready.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    lanes_d     = lanes_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    beat_s      = 1'b0;
    close_s     = 1'b0;
    case (state_q)
      FILL: begin
        beat_s = in_valid & in_ready_q;
        if (beat_s) begin
          for (int i = 0; i < LANES; i++) begin
            if (wr_idx_q == CW'(i)) lanes_d[i] = lane_op(in_a, in_b, in_mode);
            else                    lanes_d[i] = lanes_q[i];
          end
          wr_idx_d = wr_idx_q + CW'(1);
        end else begin
          wr_idx_d = wr_idx_q;
        end
        // A flush on an empty array with no beat must not emit an empty frame.
        close_s = (beat_s && (wr_idx_q == CW'(LANES - 1))) ||
                  (flush && (beat_s || (wr_idx_q != CW'(0))));
        if (close_s) begin
          state_d     = HOLD;
          out_data_d  = pack(lanes_d);
          out_count_d = wr_idx_d;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = FILL;
          wr_idx_d = '0;
          lanes_d  = '0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d  = FILL;
        wr_idx_d = '0;
        lanes_d  = '0;
      end
    endcase
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == HOLD);
  end

  // State, lane array and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      lanes_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      lanes_q     <= lanes_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef VECPACK_PARITY_EN
  logic [LANES-1:0] out_parity_q, out_parity_d;

  function automatic logic [LANES-1:0] lane_parity(input logic [LANES-1:0][W-1:0] lanes);
    lane_parity = '0;
    for (int i = 0; i < LANES; i++) lane_parity[LANES-1-i] = ^lanes[i];
  endfunction

  // Parity is captured on the same edge as out_data.
  always_comb begin
    out_parity_d = out_parity_q;
    if (close_s) out_parity_d = lane_parity(lanes_d);
    else         out_parity_d = out_parity_q;
  end

  // Parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_parity_q <= '0;
    else        out_parity_q <= out_parity_d;
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_vector_pack_engine.sv
// Self-checking bench for vector_pack_engine: directed cases plus a random stream against a frame-level model.
module tb_vector_pack_engine;
  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int CW    = $clog2(LANES + 1);
  localparam int DW    = LANES * W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic [1:0]    in_mode   = 2'b00;
  logic          flush     = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
`ifdef VECPACK_PARITY_EN
  logic [LANES-1:0] out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: lanes accepted so far, and the pending frame if any.
  logic [W-1:0]     m_lanes[$];
  bit               m_pend = 1'b0;
  bit               m_rdy  = 1'b0;
  logic [DW-1:0]    m_data = '0;
  int               m_cnt  = 0;
  logic [LANES-1:0] m_par  = '0;

  always #5 clk = ~clk;

  vector_pack_engine #(.W(W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef VECPACK_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int a, input int b, input int mode);
    int m;
    m = 1 << W;
    case (mode)
      0:       return W'(a);
      1:       return W'(b);
      2:       return W'((a + b) % m);
      default: return W'((a - b + m) % m);
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_pack(input logic [W-1:0] q[$]);
    logic [DW-1:0] v;
    v = '0;
    foreach (q[i]) v[(LANES-1-i)*W +: W] = q[i];
    return v;
  endfunction

  function automatic logic [LANES-1:0] ref_par(input logic [W-1:0] q[$]);
    logic [LANES-1:0] p;
    p = '0;
    foreach (q[i]) p[LANES-1-i] = (($countones(q[i]) % 2) == 1);
    return p;
  endfunction

  task automatic check_outputs(input string ph);
    check_eq({ph, "_in_ready"}, 64'(in_ready), 64'(m_rdy));
    check_eq({ph, "_out_valid"}, 64'(out_valid), 64'(m_pend));
    if (m_pend) begin
      check_eq({ph, "_out_data"}, 64'(out_data), 64'(m_data));
      check_eq({ph, "_out_count"}, 64'(out_count), 64'(m_cnt));
`ifdef VECPACK_PARITY_EN
      check_eq({ph, "_out_parity"}, 64'(out_parity), 64'(m_par));
`endif
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] mode, input bit fl, input bit ordy, input string ph);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = mode;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    if (rst_n) begin
      if (!m_pend) begin
        if (v && m_rdy) m_lanes.push_back(ref_op(int'(a), int'(b), int'(mode)));
        if ((m_lanes.size() == LANES) || (fl && (m_lanes.size() > 0))) begin
          m_pend = 1'b1;
          m_data = ref_pack(m_lanes);
          m_cnt  = m_lanes.size();
          m_par  = ref_par(m_lanes);
          m_lanes.delete();
        end
      end else if (ordy) begin
        m_pend = 1'b0;
      end
      m_rdy = !m_pend;
    end
    #1;
    check_outputs(ph);
  endtask

  task automatic async_reset(input string ph);
    rst_n = 1'b0;
    m_lanes.delete();
    m_pend = 1'b0;
    m_rdy  = 1'b0;
    #1;
    check_eq({ph, "_rst_valid"}, 64'(out_valid), 64'd0);
    check_eq({ph, "_rst_ready"}, 64'(in_ready), 64'd0);
    check_eq({ph, "_rst_data"}, 64'(out_data), 64'd0);
    check_eq({ph, "_rst_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    #1;
    check_eq("reset_data", 64'(out_data), 64'd0);
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_ready", 64'(in_ready), 64'd0);
    check_eq("reset_count", 64'(out_count), 64'd0);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "rst_hold");
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "rst_rel");
    check_eq("ready_after_release", 64'(in_ready), 64'd1);

    // Four modes on one operand pair.
    cycle(1'b1, 8'h12, 8'h34, 2'b00, 1'b0, 1'b1, "t1");
    cycle(1'b1, 8'h12, 8'h34, 2'b01, 1'b0, 1'b1, "t1");
    cycle(1'b1, 8'h12, 8'h34, 2'b10, 1'b0, 1'b1, "t1");
    cycle(1'b1, 8'h12, 8'h34, 2'b11, 1'b0, 1'b1, "t1");
    check_eq("t1_data", 64'(out_data), 64'h123446DE);
    check_eq("t1_count", 64'(out_count), 64'd4);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "t1_rel");
    check_eq("t1_one_cycle", 64'(out_valid), 64'd0);

    // Modular wrap of sum and difference.
    cycle(1'b1, 8'hFF, 8'h01, 2'b10, 1'b0, 1'b1, "t2");
    cycle(1'b1, 8'h00, 8'h01, 2'b11, 1'b0, 1'b1, "t2");
    cycle(1'b1, 8'hAB, 8'h00, 2'b00, 1'b0, 1'b1, "t2");
    cycle(1'b1, 8'h00, 8'hCD, 2'b01, 1'b0, 1'b1, "t2");
    check_eq("t2_data", 64'(out_data), 64'h00FFABCD);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "t2_rel");

    // Backpressure: offered beats during the stall must not be consumed.
    for (int i = 0; i < LANES; i++)
      cycle(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0, 1'b0, "t3_fill");
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b1, 1'b0, "t3_stall");
      check_eq("t3_stable", 64'(out_data), 64'(held));
      check_eq("t3_blocked", 64'(in_ready), 64'd0);
    end
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "t3_rel");
    check_eq("t3_ready_back", 64'(in_ready), 64'd1);

    // Flush of a partial frame, empty flush, flush with a coincident beat.
    cycle(1'b1, 8'hAA, 8'h00, 2'b00, 1'b0, 1'b0, "t4");
    cycle(1'b1, 8'h00, 8'hBB, 2'b01, 1'b0, 1'b0, "t4");
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, "t4_flush");
    check_eq("t4_data2", 64'(out_data), 64'hAABB0000);
    check_eq("t4_count2", 64'(out_count), 64'd2);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "t4_rel");
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, "t4_empty");
    check_eq("t4_no_empty_frame", 64'(out_valid), 64'd0);
    cycle(1'b1, 8'hAA, 8'h00, 2'b00, 1'b0, 1'b0, "t4b");
    cycle(1'b1, 8'h00, 8'hBB, 2'b01, 1'b0, 1'b0, "t4b");
    cycle(1'b1, 8'hCC, 8'h00, 2'b00, 1'b1, 1'b0, "t4b_flush");
    check_eq("t4_data3", 64'(out_data), 64'hAABBCC00);
    check_eq("t4_count3", 64'(out_count), 64'd3);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "t4b_rel");

`ifdef VECPACK_PARITY_EN
    cycle(1'b1, 8'h01, 8'h00, 2'b00, 1'b0, 1'b0, "tp");
    cycle(1'b1, 8'h03, 8'h00, 2'b00, 1'b0, 1'b0, "tp");
    cycle(1'b1, 8'h07, 8'h00, 2'b00, 1'b0, 1'b0, "tp");
    cycle(1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "tp");
    check_eq("tp_parity", 64'(out_parity), 64'b1010);
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, "tp_rel");
`endif

    // Reset mid-frame discards the partial frame.
    cycle(1'b1, 8'h11, 8'h00, 2'b00, 1'b0, 1'b0, "t5");
    cycle(1'b1, 8'h22, 8'h00, 2'b00, 1'b0, 1'b0, "t5");
    #2;
    async_reset("t5_mid");
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "t5_inrst");
    rst_n = 1'b1;
    for (int i = 0; i < LANES + 1; i++)
      cycle(i > 0, 8'h40 + 8'(i), 8'h00, 2'b00, 1'b0, 1'b0, "t5_new");
    check_eq("t5_new_data", 64'(out_data), 64'h41424344);
    // Reset while a frame is pending drops out_valid at once.
    #2;
    async_reset("t5_hold");
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "t5_inrst2");
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, "t5_rel2");

    // Random stream against the model.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 2'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
